// File: rtl/anim_step_timer.sv
// Step pacing for the LED-bar fill/drain animation: phase FSM, step strobes, step index and blink.
// Optional blink counter for clk_out enabled by defining ANIM_STEP_TIMER_BLINK_EN.
module anim_step_timer #(
  parameter int UP_DIV    = 12,
  parameter int DOWN_DIV  = 2300,
  parameter int BLINK_DIV = 4,
  parameter int STEPS     = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start_up,
  input  logic                     down,
  output logic                     ready,
  output logic                     ready_d,
  output logic                     clk_out,
  output logic [1:0]               phase,
  output logic [$clog2(STEPS)-1:0] step,
  output logic                     done
);

  localparam int DIV_MAX = (UP_DIV > DOWN_DIV) ? UP_DIV : DOWN_DIV;
  localparam int DW      = $clog2(DIV_MAX);
  localparam int SW      = $clog2(STEPS);

  localparam logic [DW-1:0] UP_LAST   = DW'(UP_DIV - 1);
  localparam logic [DW-1:0] DOWN_LAST = DW'(DOWN_DIV - 1);
  localparam logic [SW-1:0] STEP_LAST = SW'(STEPS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_UP   = 2'b01,
    S_DOWN = 2'b10
  } state_t;

  state_t          state_reg;
  state_t          state_next;
  logic [DW-1:0]   div_cnt_reg;
  logic            state_change;
  logic            up_strobe;
  logic            down_strobe;

`ifdef ANIM_STEP_TIMER_BLINK_EN
  localparam int           BW         = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
  logic [BW-1:0]           blink_cnt_reg;
`else
  // An out-of-range BLINK_DIV leaves the LED dark rather than silently solid.
  localparam bit BLINK_OK = (BLINK_DIV >= 1);
`endif

  // Every state obeys the same priority: start_up, then down, else idle.
  always_comb begin
    state_next = S_IDLE;
    if (start_up) begin
      state_next = S_UP;
    end else if (down) begin
      state_next = S_DOWN;
    end
  end

  assign state_change = (state_next != state_reg);

  // Staying in a phase already implies its request is still held.
  assign up_strobe   = (state_reg == S_UP)   && !state_change && (div_cnt_reg == UP_LAST);
  assign down_strobe = (state_reg == S_DOWN) && !state_change && (div_cnt_reg == DOWN_LAST);

  assign phase = state_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= S_IDLE;
      div_cnt_reg <= '0;
      ready       <= 1'b0;
      ready_d     <= 1'b0;
      step        <= '0;
      done        <= 1'b0;
      clk_out     <= 1'b0;
`ifdef ANIM_STEP_TIMER_BLINK_EN
      blink_cnt_reg <= '0;
`endif
    end else begin
      state_reg <= state_next;
      ready     <= up_strobe;
      ready_d   <= down_strobe;
      done      <= 1'b0;

      if (state_change || (state_next == S_IDLE) || up_strobe || down_strobe) begin
        div_cnt_reg <= '0;
      end else begin
        div_cnt_reg <= div_cnt_reg + DW'(1);
      end

      if (state_change) begin
        step <= '0;
      end else if (up_strobe || down_strobe) begin
        if (step == STEP_LAST) begin
          step <= '0;
          done <= 1'b1;
        end else begin
          step <= step + SW'(1);
        end
      end

`ifdef ANIM_STEP_TIMER_BLINK_EN
      // Only leaving or entering IDLE resets the blink; UP<->DOWN keeps its phase.
      if (state_next == S_IDLE) begin
        clk_out       <= 1'b0;
        blink_cnt_reg <= '0;
      end else if (state_reg == S_IDLE) begin
        clk_out       <= 1'b1;
        blink_cnt_reg <= '0;
      end else if (blink_cnt_reg == BLINK_LAST) begin
        clk_out       <= ~clk_out;
        blink_cnt_reg <= '0;
      end else begin
        blink_cnt_reg <= blink_cnt_reg + BW'(1);
      end
`else
      clk_out <= (state_next != S_IDLE) && BLINK_OK;
`endif
    end
  end

endmodule
